// File: rtl/fifo_pkg.sv
// Shared defaults and read-mode encoding for the synchronous FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 2;

    // STD: registered read data one cycle after the pop.
    // FWFT: head word is shown as soon as the FIFO is non-empty.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/fifo_sync_mem.sv
// Storage array for fifo_sync_flex: one write port, one read port shaped by MODE.
// Latency: write lands at the clk edge; read is 1 cycle (STD) or combinational (FWFT).
// Backpressure: none; the caller only issues accepted reads and writes.
module fifo_sync_mem
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int         ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter fifo_mode_e MODE       = FIFO_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Storage is deliberately not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        // Capture the head word on a pop; hold the last popped word otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data <= '0;
            end else if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end else begin : g_fwft
        // rd_en here means "head is valid"; output is quiet when nothing is stored.
        assign rd_data = (rd_en && !rst) ? mem[rd_addr] : '0;
    end

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with selectable STD/FWFT read mode, threshold and sticky error flags.
// Latency: write visible 1 cycle later; STD read data 1 cycle after pop, FWFT head shown directly.
// Backpressure: writes rejected while full, reads rejected while empty; rejections set sticky flags.
module fifo_sync_flex
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH    = fifo_pkg::DATA_WIDTH,
    parameter int         ADDR_WIDTH    = fifo_pkg::ADDR_WIDTH,
    parameter fifo_mode_e MODE          = FIFO_STD,
    parameter int         AFULL_THRESH  = 2 ** ADDR_WIDTH - 1,
    parameter int         AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int              DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_TH   = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_TH   = AEMPTY_THRESH[ADDR_WIDTH:0];

    if (!((AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH <= DEPTH))) begin : g_bad_thresh
        $error("fifo_sync_flex: thresholds must satisfy AEMPTY_THRESH < AFULL_THRESH <= depth");
    end

    // Extra MSB on each pointer tells a full FIFO apart from an empty one.
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                wr_acc;
    logic                rd_acc;
    logic                mem_rd_en;

    // Accept decisions use only the flags registered at the previous edge.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // Advance pointers on accepted requests; both may move in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Flags are pure functions of the pointer registers, so no request reaches them combinationally.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                          (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);

    // Sticky error flags: a new rejection beats a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en & full)  | (overflow  & ~err_clr);
            underflow <= (rd_en & empty) | (underflow & ~err_clr);
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        assign mem_rd_en = rd_acc;
        // Valid pulse lines up with the registered read data.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_acc;
            end
        end
    end else begin : g_fwft
        assign mem_rd_en = ~empty;
        assign rd_valid  = ~empty;
    end

    fifo_sync_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MODE       (MODE)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (mem_rd_en),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Directed bench: one STD and one FWFT instance share stimulus, each checked against hand values.
// Latency: inputs change 1 time unit after posedge, outputs sampled at that same point.
// Backpressure: exercised through full/empty rejection cases.
module tb_fifo_sync_flex;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] wr_data;

    logic [7:0] s_rd_data, f_rd_data;
    logic       s_rd_valid, f_rd_valid;
    logic       s_full, f_full, s_empty, f_empty;
    logic       s_afull, f_afull, s_aempty, f_aempty;
    logic [2:0] s_count, f_count;
    logic       s_ovf, f_ovf, s_udf, f_udf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_sync_flex #(
        .DATA_WIDTH (8), .ADDR_WIDTH (2), .MODE (FIFO_STD),
        .AFULL_THRESH (3), .AEMPTY_THRESH (1)
    ) u_std (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_data (wr_data), .rd_en (rd_en),
        .rd_data (s_rd_data), .rd_valid (s_rd_valid), .full (s_full), .empty (s_empty),
        .almost_full (s_afull), .almost_empty (s_aempty), .count (s_count),
        .overflow (s_ovf), .underflow (s_udf), .err_clr (err_clr)
    );

    fifo_sync_flex #(
        .DATA_WIDTH (8), .ADDR_WIDTH (2), .MODE (FIFO_FWFT),
        .AFULL_THRESH (3), .AEMPTY_THRESH (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_data (wr_data), .rd_en (rd_en),
        .rd_data (f_rd_data), .rd_valid (f_rd_valid), .full (f_full), .empty (f_empty),
        .almost_full (f_afull), .almost_empty (f_aempty), .count (f_count),
        .overflow (f_ovf), .underflow (f_udf), .err_clr (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
        tick();
        tick();
        // Reset state
        check("rst_count",  s_count,    0);
        check("rst_empty",  s_empty,    1);
        check("rst_full",   s_full,     0);
        check("rst_afull",  s_afull,    0);
        check("rst_aempty", s_aempty,   1);
        check("rst_valid",  s_rd_valid, 0);
        check("rst_data",   s_rd_data,  0);
        check("rst_ovf",    s_ovf,      0);
        check("rst_udf",    s_udf,      0);
        check("rst_f_valid", f_rd_valid, 0);
        check("rst_f_data",  f_rd_data,  0);
        rst = 1'b0;

        // STD fill to full, threshold flags on the way
        for (int i = 0; i < 4; i++) begin
            push(vals[i]);
            check("std_wr_count", s_count, i + 1);
            if (i == 1) check("afull_at2", s_afull, 0);
            if (i == 2) begin
                check("afull_at3",  s_afull,  1);
                check("aempty_at3", s_aempty, 0);
            end
        end
        check("std_full",  s_full,  1);
        check("std_cnt4",  s_count, 4);

        // STD drain: data one cycle behind rd_en
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("std_rd_valid", s_rd_valid, 1);
            check("std_rd_data",  s_rd_data,  vals[i]);
            if (i == 2) check("aempty_at1", s_aempty, 1);
        end
        rd_en = 1'b0;
        tick();
        check("std_valid_drop", s_rd_valid, 0);
        check("std_empty_end",  s_empty,    1);
        check("std_data_hold",  s_rd_data,  8'h44);
        check("std_no_udf",     s_udf,      0);

        // Full with simultaneous read and write: write dropped
        for (int i = 1; i <= 4; i++) push(8'(i));
        check("ovf_pre_full", s_full, 1);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("ovf_set",   s_ovf,      1);
        check("ovf_count", s_count,    3);
        check("ovf_full",  s_full,     0);
        check("ovf_valid", s_rd_valid, 1);
        check("ovf_data",  s_rd_data,  8'h01);
        tick();
        check("ovf_hold",  s_ovf,      1);
        check("ovf_pulse", s_rd_valid, 0);
        rd_en = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("ovf_drain", s_rd_data, i);
        end
        rd_en = 1'b0;
        check("ovf_drop_empty", s_empty, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clr", s_ovf, 0);

        // Empty with simultaneous read and write: read rejected
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h66;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("udf_set",   s_udf,      1);
        check("udf_count", s_count,    1);
        check("udf_valid", s_rd_valid, 0);
        pop();
        check("udf_rd_valid", s_rd_valid, 1);
        check("udf_rd_data",  s_rd_data,  8'h66);
        tick();
        check("udf_pulse",    s_rd_valid, 0);
        rd_en = 1'b1; err_clr = 1'b1;
        tick();
        rd_en = 1'b0; err_clr = 1'b0;
        check("udf_set_wins", s_udf, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("udf_clr", s_udf, 0);

        // Mid-operation reset with a write in the reset cycle
        pop();
        push(8'h01);
        push(8'h02);
        check("rst2_pre_count", s_count, 2);
        check("rst2_pre_udf",   s_udf,   1);
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        check("rst2_count",   s_count,    0);
        check("rst2_empty",   s_empty,    1);
        check("rst2_valid",   s_rd_valid, 0);
        check("rst2_udf",     s_udf,      0);
        check("rst2_ovf",     s_ovf,      0);
        check("rst2_f_count", f_count,    0);
        check("rst2_f_valid", f_rd_valid, 0);
        tick();
        check("rst2_wr_ignored", s_count, 0);

        // FWFT: head visible the cycle after the write, no rd_en needed
        push(8'hA5);
        check("fwft_valid", f_rd_valid, 1);
        check("fwft_data",  f_rd_data,  8'hA5);
        check("fwft_nempty", f_empty,   0);
        check("std_no_valid", s_rd_valid, 0);
        pop();
        check("fwft_empty", f_empty,    1);
        check("fwft_gone",  f_rd_valid, 0);

        // FWFT simultaneous read+write at count 1: count unchanged, head advances
        push(8'h77);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h88;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rw_count", f_count,   1);
        check("rw_head",  f_rd_data, 8'h88);
        pop();
        check("rw_empty", f_empty, 1);

        // Wrap: pointers pass 7 with no false full
        for (int i = 0; i < 10; i++) begin
            push(8'(i));
            check("wrap_valid", f_rd_valid, 1);
            check("wrap_data",  f_rd_data,  i);
            check("wrap_count", f_count,    1);
            check("wrap_full",  f_full,     0);
            pop();
            check("wrap_count0", f_count, 0);
            check("wrap_full0",  f_full,  0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
